clock_monitor: RTL

CLOCK_MONITOR -- requirements
Module: clock_monitor

---
 rtl/clock_monitor.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_monitor.sv
// clock_monitor: measures period and high time of a slow divided clock (isig)
// in iclk cycles, flags out-of-tolerance periods and declares lock after
// LOCK_COUNT consecutive good periods.
// Optional feature: define CLOCK_MONITOR_TIMEOUT_EN to enable loss-of-edge
// timeout detection (otimeout pulse and return to IDLE after 2*DIVISOR
// cycles without a rise). Without it, otimeout is tied low.
module clock_monitor #(
    parameter int DIVISOR    = 25,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4,
    parameter int CW         = 8
) (
    input  logic          iclk,
    input  logic          irst_n,
    input  logic          isig,
    output logic [CW-1:0] operiod,
    output logic [CW-1:0] ohigh,
    output logic          ovalid,
    output logic          operiod_err,
    output logic          oduty_err,
    output logic          olocked,
    output logic          otimeout
);

    localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

    // Saturation value of the measurement counters; a saturated count is never good.
    localparam logic [CW-1:0]        SAT_C  = {CW{1'b1}};
    localparam logic signed [CW:0]   DIV_C  = (CW+1)'(DIVISOR);
    localparam logic signed [CW:0]   HALF_C = (CW+1)'(DIVISOR / 2);
    localparam logic signed [CW:0]   TOL_P  = (CW+1)'(TOL);
    localparam logic signed [CW:0]   TOL_N  = -TOL_P;
    localparam logic [GW-1:0]        LAST_C = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t          state_r;
    logic            sync1_r;
    logic            sync2_r;
    logic            prev_r;
    logic [CW-1:0]   period_cnt_r;
    logic [CW-1:0]   high_cnt_r;
    logic [GW-1:0]   good_cnt_r;
    logic [CW-1:0]   operiod_r;
    logic [CW-1:0]   ohigh_r;
    logic            ovalid_r;
    logic            operiod_err_r;
    logic            oduty_err_r;
    logic            olocked_r;

    logic            rise_s;
    logic signed [CW:0] pdiff_s;
    logic signed [CW:0] hdiff_s;
    logic            period_bad_s;
    logic            duty_bad_s;
    logic            good_s;

    // Rising edge of the synchronized input.
    assign rise_s = sync2_r & ~prev_r;

    // Tolerance checks on the completed counts, done in CW+1-bit signed
    // arithmetic so a short period cannot wrap into a small positive deviation.
    assign pdiff_s      = $signed({1'b0, period_cnt_r}) - DIV_C;
    assign hdiff_s      = $signed({1'b0, high_cnt_r}) - HALF_C;
    assign period_bad_s = (period_cnt_r == SAT_C) || (pdiff_s > TOL_P) || (pdiff_s < TOL_N);
    assign duty_bad_s   = (high_cnt_r == SAT_C) || (hdiff_s > TOL_P) || (hdiff_s < TOL_N);
    assign good_s       = ~period_bad_s & ~duty_bad_s;

`ifdef CLOCK_MONITOR_TIMEOUT_EN
    localparam logic [CW-1:0] TO_C = CW'(2 * DIVISOR);

    logic otimeout_r;
    logic timeout_s;

    // period_cnt_r equals the number of rise-free cycles since the last rise.
    assign timeout_s = (period_cnt_r >= TO_C);
    assign otimeout  = otimeout_r;
`else
    assign otimeout  = 1'b0;
`endif

    assign operiod     = operiod_r;
    assign ohigh       = ohigh_r;
    assign ovalid      = ovalid_r;
    assign operiod_err = operiod_err_r;
    assign oduty_err   = oduty_err_r;
    assign olocked     = olocked_r;

    // Two-flop synchronizer for isig plus a delayed copy for edge detection.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= isig;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Saturating period and high-time counters, restarted by each detected rise.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            period_cnt_r <= {CW{1'b0}};
            high_cnt_r   <= {CW{1'b0}};
        end else begin
            if (rise_s) begin
                period_cnt_r <= CW'(1);
            end else if (period_cnt_r != SAT_C) begin
                period_cnt_r <= period_cnt_r + CW'(1);
            end else begin
                period_cnt_r <= period_cnt_r;
            end

            if (rise_s) begin
                high_cnt_r <= CW'(1);
            end else if (sync2_r && (high_cnt_r != SAT_C)) begin
                high_cnt_r <= high_cnt_r + CW'(1);
            end else begin
                high_cnt_r <= high_cnt_r;
            end
        end
    end

    // Lock FSM with registered measurement outputs and one-cycle pulses.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_r       <= ST_IDLE;
            good_cnt_r    <= {GW{1'b0}};
            operiod_r     <= {CW{1'b0}};
            ohigh_r       <= {CW{1'b0}};
            ovalid_r      <= 1'b0;
            operiod_err_r <= 1'b0;
            oduty_err_r   <= 1'b0;
            olocked_r     <= 1'b0;
`ifdef CLOCK_MONITOR_TIMEOUT_EN
            otimeout_r    <= 1'b0;
`endif
        end else begin
            ovalid_r      <= 1'b0;
            operiod_err_r <= 1'b0;
            oduty_err_r   <= 1'b0;
`ifdef CLOCK_MONITOR_TIMEOUT_EN
            otimeout_r    <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    // First rise only opens a measurement window; nothing to report yet.
                    if (rise_s) begin
                        state_r    <= ST_MEASURE;
                        good_cnt_r <= {GW{1'b0}};
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_MEASURE: begin
                    if (rise_s) begin
                        operiod_r     <= period_cnt_r;
                        ohigh_r       <= high_cnt_r;
                        ovalid_r      <= 1'b1;
                        operiod_err_r <= period_bad_s;
                        oduty_err_r   <= duty_bad_s;
                        if (good_s && (good_cnt_r == LAST_C)) begin
                            state_r    <= ST_LOCKED;
                            olocked_r  <= 1'b1;
                            good_cnt_r <= {GW{1'b0}};
                        end else if (good_s) begin
                            good_cnt_r <= good_cnt_r + GW'(1);
                        end else begin
                            good_cnt_r <= {GW{1'b0}};
                        end
                    end
`ifdef CLOCK_MONITOR_TIMEOUT_EN
                    else if (timeout_s) begin
                        state_r    <= ST_IDLE;
                        otimeout_r <= 1'b1;
                        olocked_r  <= 1'b0;
                        good_cnt_r <= {GW{1'b0}};
                    end
`endif
                    else begin
                        state_r <= ST_MEASURE;
                    end
                end
                ST_LOCKED: begin
                    if (rise_s) begin
                        operiod_r     <= period_cnt_r;
                        ohigh_r       <= high_cnt_r;
                        ovalid_r      <= 1'b1;
                        operiod_err_r <= period_bad_s;
                        oduty_err_r   <= duty_bad_s;
                        if (!good_s) begin
                            state_r    <= ST_MEASURE;
                            olocked_r  <= 1'b0;
                            good_cnt_r <= {GW{1'b0}};
                        end else begin
                            state_r    <= ST_LOCKED;
                        end
                    end
`ifdef CLOCK_MONITOR_TIMEOUT_EN
                    else if (timeout_s) begin
                        state_r    <= ST_IDLE;
                        otimeout_r <= 1'b1;
                        olocked_r  <= 1'b0;
                        good_cnt_r <= {GW{1'b0}};
                    end
`endif
                    else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    olocked_r  <= 1'b0;
                    good_cnt_r <= {GW{1'b0}};
                end
            endcase
        end
    end

endmodule
